// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:4 TDM receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demux: clear, load-to-1 on frame sync, wrapping increment.
// Latency: slot updates on the clock edge after clr/load1/inc; last is combinational from slot.
// Backpressure: none; the counter holds whenever no control input is asserted.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t slot,
    output logic  last
);

    // Clear wins over a frame-sync load, which wins over a plain advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= slot_t'(1);
        end else if (inc) begin
            slot <= slot + slot_t'(1);
        end
    end

    assign last = (slot == slot_t'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// 1:4 TDM demux: scans an upstream 4:1 mux via select0/1 and reassembles 4-slot frames onto a..d.
// Latency: a..d and frame_valid register on the same edge that samples slot 3.
// Backpressure: none; en low freezes all state. Optional sync checking under TDM_SYNC_CHECK_EN.
module tdm_demux4
    import tdm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_bit,
    input  logic frame_start,
    output logic select0,
    output logic select1,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic frame_valid,
    output logic sync_err
);

    tdm_state_e state_q, state_d;
    logic [2:0] shadow_q, shadow_d;
    slot_t      slot;
    logic       last;
    logic       cnt_clr, cnt_load, cnt_inc;
    logic       out_load;
    logic       fv_d;
`ifdef TDM_SYNC_CHECK_EN
    logic       sync_err_d;
`endif

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (cnt_load),
        .inc   (cnt_inc),
        .slot  (slot),
        .last  (last)
    );

    // The counter already points at the slot the next enabled edge samples.
    assign select0 = slot[0];
    assign select1 = slot[1];

    // State and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state decode: frame sync always restarts at slot 0, slot 3 publishes the frame.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        out_load   = 1'b0;
        fv_d       = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
        sync_err_d = 1'b0;
`endif
        if (en) begin
            if (frame_start) begin
                // Start or resync; any partial frame in the shadow is abandoned.
                shadow_d[0] = in_bit;
                cnt_load    = 1'b1;
                state_d     = RUN;
`ifdef TDM_SYNC_CHECK_EN
                if (state_q == RUN && slot != slot_t'(0)) begin
                    sync_err_d = 1'b1;
                end
`endif
            end else if (state_q == IDLE) begin
                cnt_clr = 1'b1;
            end else if (slot == slot_t'(0)) begin
`ifdef TDM_SYNC_CHECK_EN
                // Expected sync never arrived: drop the sample and hunt again.
                sync_err_d = 1'b1;
                state_d    = IDLE;
                cnt_clr    = 1'b1;
`else
                // Free-running: the frame boundary is implied by the counter.
                shadow_d[0] = in_bit;
                cnt_inc     = 1'b1;
`endif
            end else if (last) begin
                out_load = 1'b1;
                fv_d     = 1'b1;
                cnt_inc  = 1'b1;
            end else begin
                case (slot)
                    slot_t'(1): shadow_d[1] = in_bit;
                    slot_t'(2): shadow_d[2] = in_bit;
                    default:    shadow_d    = shadow_q;
                endcase
                cnt_inc = 1'b1;
            end
        end
    end

    // Channel outputs load all four slots at once and hold between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= 1'b0;
            b <= 1'b0;
            c <= 1'b0;
            d <= 1'b0;
        end else if (out_load) begin
            a <= shadow_q[0];
            b <= shadow_q[1];
            c <= shadow_q[2];
            d <= in_bit;
        end
    end

    // One-cycle frame strobe; drops on any edge that does not complete a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= fv_d;
        end
    end

`ifdef TDM_SYNC_CHECK_EN
    // One-cycle sync violation strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= sync_err_d;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic in_bit;
    logic frame_start;
    logic select0, select1;
    logic a, b, c, d;
    logic frame_valid;
    logic sync_err;

`ifdef TDM_SYNC_CHECK_EN
    localparam bit SYNC_CHK = 1'b1;
`else
    localparam bit SYNC_CHK = 1'b0;
`endif

    tdm_demux4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_bit      (in_bit),
        .frame_start (frame_start),
        .select0     (select0),
        .select1     (select1),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fs;
        logic       en;
        logic       din;
        logic [1:0] sel;
        logic [3:0] abcd;
        logic       fv;
        logic       se;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_q[$];
    logic [3:0] sb_exp;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] sel, input logic [3:0] abcd,
                             input logic fv, input logic se);
        check({tag, " select"},      {6'd0, select1, select0}, {6'd0, sel});
        check({tag, " abcd"},        {4'd0, a, b, c, d},       {4'd0, abcd});
        check({tag, " frame_valid"}, {7'd0, frame_valid},      {7'd0, fv});
        check({tag, " sync_err"},    {7'd0, sync_err},         {7'd0, se});
    endtask

    task automatic step(input logic fs, input logic e, input logic din);
        @(negedge clk);
        frame_start = fs;
        en          = e;
        in_bit      = din;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fs, input logic e, input logic din, input logic [1:0] sel,
                       input logic [3:0] abcd, input logic fv, input logic se);
        vec_t v;
        v.fs = fs; v.en = e; v.din = din; v.sel = sel; v.abcd = abcd; v.fv = fv; v.se = se;
        vecs.push_back(v);
    endtask

    // Scoreboard: every frame_valid must match the next frame the stimulus completed.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: unexpected frame_valid, abcd=%b", {a, b, c, d});
            end else begin
                sb_exp = sb_q.pop_front();
                check("scoreboard frame", {4'd0, a, b, c, d}, {4'd0, sb_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] ms_sel[4];
        logic [3:0] ms_abcd[4];
        logic       ms_fv[4];
        logic       ms_se[4];
        logic       ms_din[4];

        // IDLE without sync, then frame 0,0,1,0
        add(0, 1, 1, 2'd0, 4'b0000, 0, 0);
        add(1, 1, 0, 2'd1, 4'b0000, 0, 0);
        add(0, 1, 0, 2'd2, 4'b0000, 0, 0);
        add(0, 1, 1, 2'd3, 4'b0000, 0, 0);
        add(0, 1, 0, 2'd0, 4'b0010, 1, 0);
        // back-to-back 1,0,1,0 then 0,1,1,1
        add(1, 1, 1, 2'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 2'd2, 4'b0010, 0, 0);
        add(0, 1, 1, 2'd3, 4'b0010, 0, 0);
        add(0, 1, 0, 2'd0, 4'b1010, 1, 0);
        add(1, 1, 0, 2'd1, 4'b1010, 0, 0);
        add(0, 1, 1, 2'd2, 4'b1010, 0, 0);
        add(0, 1, 1, 2'd3, 4'b1010, 0, 0);
        add(0, 1, 1, 2'd0, 4'b0111, 1, 0);
        // en low for 5 cycles at slot 2 (frame_start ignored), frame 1,1,0,1
        add(1, 1, 1, 2'd1, 4'b0111, 0, 0);
        add(0, 1, 1, 2'd2, 4'b0111, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 0, logic'(i[0]), 2'd2, 4'b0111, 0, 0);
        add(0, 1, 0, 2'd3, 4'b0111, 0, 0);
        add(0, 1, 1, 2'd0, 4'b1101, 1, 0);
        // resync at slot 2, then frame 0,1,1,0
        add(1, 1, 1, 2'd1, 4'b1101, 0, 0);
        add(0, 1, 0, 2'd2, 4'b1101, 0, 0);
        add(1, 1, 0, 2'd1, 4'b1101, 0, 1);
        add(0, 1, 1, 2'd2, 4'b1101, 0, 0);
        add(0, 1, 1, 2'd3, 4'b1101, 0, 0);
        add(0, 1, 0, 2'd0, 4'b0110, 1, 0);
        // sync on the slot-3 edge wins over frame completion, then frame 0,0,0,1
        add(1, 1, 1, 2'd1, 4'b0110, 0, 0);
        add(0, 1, 1, 2'd2, 4'b0110, 0, 0);
        add(0, 1, 1, 2'd3, 4'b0110, 0, 0);
        add(1, 1, 0, 2'd1, 4'b0110, 0, 1);
        add(0, 1, 0, 2'd2, 4'b0110, 0, 0);
        add(0, 1, 0, 2'd3, 4'b0110, 0, 0);
        add(0, 1, 1, 2'd0, 4'b0001, 1, 0);

        rst_n = 1'b0; en = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].fv) sb_q.push_back(vecs[i].abcd);
            step(vecs[i].fs, vecs[i].en, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].abcd, vecs[i].fv,
                      vecs[i].se & SYNC_CHK);
        end

        // Missing frame_start at slot 0 in RUN, serial 1,0,1,1
        ms_din = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef TDM_SYNC_CHECK_EN
        ms_sel  = '{2'd0, 2'd0, 2'd0, 2'd0};
        ms_abcd = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        ms_fv   = '{1'b0, 1'b0, 1'b0, 1'b0};
        ms_se   = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
        ms_sel  = '{2'd1, 2'd2, 2'd3, 2'd0};
        ms_abcd = '{4'b0001, 4'b0001, 4'b0001, 4'b1011};
        ms_fv   = '{1'b0, 1'b0, 1'b0, 1'b1};
        ms_se   = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (ms_fv[i]) sb_q.push_back(ms_abcd[i]);
            step(1'b0, 1'b1, ms_din[i]);
            check_all($sformatf("nosync%0d", i), ms_sel[i], ms_abcd[i], ms_fv[i], ms_se[i]);
        end

        // Reset asserted mid-frame at slot 2
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("midreset pre select", {6'd0, select1, select0}, 8'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("async reset", 2'd0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check_all($sformatf("post-reset idle%0d", i), 2'd0, 4'b0000, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        check_all("post-reset s0", 2'd1, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_all("post-reset s1", 2'd2, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_all("post-reset s2", 2'd3, 4'b0000, 1'b0, 1'b0);
        sb_q.push_back(4'b1111);
        step(1'b0, 1'b1, 1'b1);
        check_all("post-reset s3", 2'd0, 4'b1111, 1'b1, 1'b0);

        @(negedge clk);
        check("scoreboard drained", 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
